// File: rtl/button_debouncer.sv
// Debounces one raw, bouncing button pin into a clean clock-synchronous level.
// A new level must be held for STABLE_CYCLES synchronized samples before btn_db follows.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned CNT_W         = 19
) (
  input  logic clk,
  input  logic res,
  input  logic btn_raw,
  output logic btn_db,
  output logic busy
);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync0_r;
  logic             sync1_r;
  logic             btn_s;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             btn_db_r;
  logic             busy_r;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync0_r <= 1'b0;
      sync1_r <= 1'b0;
    end else begin
      sync0_r <= btn_raw;
      sync1_r <= sync0_r;
    end
  end

  assign btn_s = sync1_r;

  // Qualification FSM; outputs are loaded with the next-state decode on the same edge.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r  <= S_LOW;
      cnt_r    <= CNT_ZERO;
      btn_db_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        S_LOW: begin
          cnt_r    <= CNT_ZERO;
          btn_db_r <= 1'b0;
          if (btn_s) begin
            state_r <= S_RISE;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_LOW;
            busy_r  <= 1'b0;
          end
        end
        S_RISE: begin
          if (!btn_s) begin
            state_r  <= S_LOW;
            cnt_r    <= CNT_ZERO;
            btn_db_r <= 1'b0;
            busy_r   <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r  <= S_HIGH;
            cnt_r    <= CNT_ZERO;
            btn_db_r <= 1'b1;
            busy_r   <= 1'b0;
          end else begin
            state_r  <= S_RISE;
            cnt_r    <= cnt_r + CNT_ONE;
            btn_db_r <= 1'b0;
            busy_r   <= 1'b1;
          end
        end
        S_HIGH: begin
          cnt_r    <= CNT_ZERO;
          btn_db_r <= 1'b1;
          if (!btn_s) begin
            state_r <= S_FALL;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_HIGH;
            busy_r  <= 1'b0;
          end
        end
        S_FALL: begin
          if (btn_s) begin
            state_r  <= S_HIGH;
            cnt_r    <= CNT_ZERO;
            btn_db_r <= 1'b1;
            busy_r   <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r  <= S_LOW;
            cnt_r    <= CNT_ZERO;
            btn_db_r <= 1'b0;
            busy_r   <= 1'b0;
          end else begin
            state_r  <= S_FALL;
            cnt_r    <= cnt_r + CNT_ONE;
            btn_db_r <= 1'b1;
            busy_r   <= 1'b1;
          end
        end
        default: begin
          state_r  <= S_LOW;
          cnt_r    <= CNT_ZERO;
          btn_db_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign btn_db = btn_db_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, CNT_W=3.
// Edge numbers count from the first edge that samples a new btn_raw level.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic res;
  logic btn_raw;
  logic btn_db;
  logic busy;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic prev_db = 1'b0;

  button_debouncer #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk     (clk),
    .res     (res),
    .btn_raw (btn_raw),
    .btn_db  (btn_db),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later; also acts as the downstream edge detector.
  task automatic tick();
    @(posedge clk);
    #1;
    if (btn_db === 1'b1 && prev_db === 1'b0) rises++;
    prev_db = btn_db;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] exp_busy3;
    int pat3 [7];
    exp_busy3 = 20'h01ECC;
    pat3 = '{1, 1, 0, 0, 1, 1, 0};

    // 1: reset held with the button pressed
    res = 1'b1;
    btn_raw = 1'b1;
    #1;
    check("t1 db async", btn_db, 1'b0);
    check("t1 busy async", busy, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("t1 db c%0d", e), btn_db, 1'b0);
      check($sformatf("t1 busy c%0d", e), busy, 1'b0);
    end
    btn_raw = 1'b0;
    tick();
    res = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("idle db c%0d", e), btn_db, 1'b0);
      check($sformatf("idle busy c%0d", e), busy, 1'b0);
    end

    // 2: clean press
    btn_raw = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check($sformatf("t2 busy e%0d", e), busy, (e >= 3 && e <= 6) ? 1'b1 : 1'b0);
      check($sformatf("t2 db e%0d", e), btn_db, (e >= 7) ? 1'b1 : 1'b0);
    end
    check("t2 pe count", rises, 1);

    // 4: three-cycle low glitch while high
    btn_raw = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) btn_raw = 1'b1;
      check($sformatf("t4 busy e%0d", e), busy, (e >= 3 && e <= 5) ? 1'b1 : 1'b0);
      check($sformatf("t4 db e%0d", e), btn_db, 1'b1);
    end

    // 5: release
    btn_raw = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("t5 busy e%0d", e), busy, (e >= 3 && e <= 6) ? 1'b1 : 1'b0);
      check($sformatf("t5 db e%0d", e), btn_db, (e < 7) ? 1'b1 : 1'b0);
    end

    // 3: bounce then steady press
    for (int e = 1; e <= 20; e++) begin
      btn_raw = (e <= 7) ? pat3[e-1][0] : 1'b1;
      tick();
      check($sformatf("t3 busy e%0d", e), busy, exp_busy3[e-1]);
      check($sformatf("t3 db e%0d", e), btn_db, (e >= 14) ? 1'b1 : 1'b0);
    end
    check("t3 pe count", rises, 2);

    // return low before the reset-during-qualification case
    btn_raw = 1'b0;
    for (int e = 1; e <= 12; e++) tick();
    check("t6 pre db", btn_db, 1'b0);

    // 6: reset pulse while qualifying a press
    btn_raw = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    check("t6 busy in rise", busy, 1'b1);
    res = 1'b1;
    #1;
    check("t6 db async", btn_db, 1'b0);
    check("t6 busy async", busy, 1'b0);
    for (int e = 1; e <= 2; e++) begin
      tick();
      check($sformatf("t6 busy held c%0d", e), busy, 1'b0);
    end
    res = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("t6 busy e%0d", e), busy, (e >= 3 && e <= 6) ? 1'b1 : 1'b0);
      check($sformatf("t6 db e%0d", e), btn_db, (e >= 7) ? 1'b1 : 1'b0);
    end
    check("t6 pe count", rises, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
